// File: rtl/pkt_builder_pkg.sv
// Shared types and constants for the exchange packet builder.
// Field order helper matches the parser's byte-swap view of the wire.
package pkt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MSG,
    FLUSH
  } build_fsm_t;

  localparam int HDR_BYTES  = 2;
  localparam int LEN_BYTES  = 2;
  localparam int BEAT_BYTES = 8;
  localparam int ACC_BYTES  = 24;
  localparam int APP_BYTES  = LEN_BYTES + BEAT_BYTES;

  // First wire byte lands in [15:8].
  function automatic logic [15:0] be16(input logic [15:0] v);
    logic [1:0][7:0] w;
    w[1] = v[15:8];
    w[0] = v[7:0];
    return w;
  endfunction

endpackage

// File: rtl/pkt_builder_if.sv
// Avalon-ST style stream bundle used on both sides of the builder.
// The sink side ignores error; the source side drives it.
interface avalon_stream;

  logic [63:0] data;
  logic        valid;
  logic        ready;
  logic        sop;
  logic        eop;
  logic [2:0]  empty;
  logic        error;

  modport master (
    output data, valid, sop, eop, empty, error,
    input  ready
  );

  modport slave (
    input  data, valid, sop, eop, empty,
    output ready
  );

endinterface

// File: rtl/pkt_builder_byte_acc.sv
// Byte queue for the builder: header load, append up to 10 bytes,
// and drain one 8-byte word from the front, all in one cycle.
module pkt_byte_acc #(
  parameter int BYTES = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [15:0] load_hdr_i,
  input  logic        drain_i,
  input  logic        app_en_i,
  input  logic [3:0]  app_n_i,
  input  logic [79:0] app_data_i,
  output logic [63:0] word_o,
  output logic [4:0]  bytes_o
);
  import pkt_pkg::*;

  localparam int W = BYTES * 8;

  logic [W-1:0]  acc_q, acc_d, base;
  logic [4:0]    cnt_q, cnt_d, cnt_base;
  logic [79:0]   app_mask;
  logic [W-1:0]  app_ext;

  // Bytes past cnt_q are kept zero so append can simply OR in.
  always_comb begin
    base     = drain_i ? {acc_q[W-65:0], 64'h0} : acc_q;
    cnt_base = cnt_q;
    if (drain_i)
      cnt_base = (cnt_q >= 5'd8) ? cnt_q - 5'd8 : 5'd0;
    app_mask = ~({80{1'b1}} >> {app_n_i, 3'b000});
    app_ext  = {app_data_i & app_mask, {(W-80){1'b0}}}
               >> {cnt_base, 3'b000};
    acc_d    = base;
    cnt_d    = cnt_base;
    if (app_en_i) begin
      acc_d = base | app_ext;
      cnt_d = cnt_base + {1'b0, app_n_i};
    end
    if (load_i) begin
      acc_d = {load_hdr_i, {(W-16){1'b0}}};
      cnt_d = 5'(HDR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o  = acc_q[W-1 -: 64];
  assign bytes_o = cnt_q;

endmodule

// File: rtl/pkt_builder.sv
// Packs a message stream into count/length-prefixed 64-bit packets.
// Handshake outputs depend on registers only, never on valid/ready.
module pkt_builder #(
  parameter bit LEN_CHECK = 1'b1,
  parameter int ACC_BYTES = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  avalon_stream.slave  message,
  input  logic [15:0]  msg_len,
  input  logic [15:0]  cfg_msg_count,
  avalon_stream.master data_packet,
  output logic         busy
);
  import pkt_pkg::*;

  localparam logic [4:0] RDY_MAX = 5'(ACC_BYTES - APP_BYTES);

  build_fsm_t  state_q;
  logic [15:0] msg_rem_q, len_q, bcnt_q;
  logic        first_q, pkt_err_q, in_msg_q;

  logic [63:0] word;
  logic [4:0]  acc_bytes, emp_w;
  logic        is_flush, pv, peop, drain;
  logic        mready, take, start, len_bad;
  logic [3:0]  dbytes, app_n;
  logic [79:0] app_data;
  logic [15:0] bsum, blen;

  always_comb begin
    is_flush = state_q == FLUSH;
    pv       = acc_bytes >= 5'd8 ||
               (is_flush && acc_bytes != 5'd0);
    peop     = pv && is_flush && acc_bytes <= 5'd8;
    drain    = pv && data_packet.ready;
    mready   = state_q == MSG && acc_bytes <= RDY_MAX;
    take     = mready && message.valid;
    start    = state_q == IDLE && message.valid && message.sop;
    dbytes   = message.eop ? 4'd8 - {1'b0, message.empty} : 4'd8;
    app_n    = message.sop ? dbytes + 4'(LEN_BYTES) : dbytes;
    app_data = message.sop ? {be16(msg_len), message.data}
                           : {message.data, 16'h0};
    bsum     = (message.sop ? 16'h0 : bcnt_q) + {12'h0, dbytes};
    blen     = message.sop ? msg_len : len_q;
    len_bad  = LEN_CHECK && message.eop && bsum != blen;
    emp_w    = 5'd8 - acc_bytes;
  end

  pkt_byte_acc #(.BYTES(ACC_BYTES)) u_acc (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (start),
    .load_hdr_i (be16(cfg_msg_count)),
    .drain_i    (drain),
    .app_en_i   (take),
    .app_n_i    (app_n),
    .app_data_i (app_data),
    .word_o     (word),
    .bytes_o    (acc_bytes)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      msg_rem_q <= '0;
      len_q     <= '0;
      bcnt_q    <= '0;
      first_q   <= 1'b1;
      pkt_err_q <= 1'b0;
      in_msg_q  <= 1'b0;
    end else begin
      if (drain)
        first_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          state_q   <= MSG;
          msg_rem_q <= cfg_msg_count;
          first_q   <= 1'b1;
          pkt_err_q <= cfg_msg_count == 16'h0;
          in_msg_q  <= 1'b0;
        end
        MSG: if (take) begin
          if (message.sop)
            len_q <= msg_len;
          bcnt_q   <= bsum;
          in_msg_q <= !message.eop;
          if ((message.sop && in_msg_q) || len_bad)
            pkt_err_q <= 1'b1;
          if (message.eop) begin
            if (msg_rem_q != 16'h0)
              msg_rem_q <= msg_rem_q - 16'h1;
            // A zero count still closes after one message.
            if (msg_rem_q <= 16'h1)
              state_q <= FLUSH;
          end
        end
        FLUSH: if (drain && peop)
          state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_packet.data  = word;
  assign data_packet.valid = pv;
  assign data_packet.sop   = pv && first_q;
  assign data_packet.eop   = peop;
  assign data_packet.empty = peop ? emp_w[2:0] : 3'd0;
  assign data_packet.error = peop && pkt_err_q;
  assign message.ready     = mready;
  assign busy              = state_q != IDLE;

endmodule

// File: tb/tb_pkt_builder.sv
// Randomized bench for pkt_builder against a byte-stream packet model.
// Also tracks expected queue occupancy to check both handshakes.
module tb_pkt_builder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] msg_len;
  logic [15:0] cfg_msg_count;
  logic        busy;

  avalon_stream msg_if ();
  avalon_stream pkt_if ();

  pkt_builder #(.LEN_CHECK(1'b1), .ACC_BYTES(24)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .message       (msg_if.slave),
    .msg_len       (msg_len),
    .cfg_msg_count (cfg_msg_count),
    .data_packet   (pkt_if.master),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic        err;
    logic [2:0]  emp;
  } word_t;

  int          n_chk, n_fail;
  int          n_msgs, pkt_cfg;
  int          act_len[8];
  int          dec_len[8];
  logic [7:0]  mb[8][40];
  word_t       got[$];
  logic [7:0]  exp_b[$];
  logic        exp_err;
  int          sink_mode, stall_start, stall_len, gap_en;
  bit          done;

  task automatic set_msg(int i, int alen, int dlen, int first, int step);
    act_len[i] = alen;
    dec_len[i] = dlen;
    for (int k = 0; k < alen; k++)
      mb[i][k] = 8'(first + step * k);
  endtask

  task automatic set_rand(int i, int alen);
    act_len[i] = alen;
    dec_len[i] = alen;
    for (int k = 0; k < alen; k++)
      mb[i][k] = 8'($urandom);
  endtask

  task automatic drive_msgs();
    bit abort = 0;
    for (int i = 0; i < n_msgs && !abort; i++) begin
      int nb = (act_len[i] + 7) / 8;
      for (int b = 0; b < nb && !abort; b++) begin
        logic [63:0] d = '0;
        bit acc = 0;
        int w = 0;
        for (int k = 0; k < 8; k++) begin
          int idx = b * 8 + k;
          logic [7:0] by;
          by = (idx < act_len[i]) ? mb[i][idx] : 8'($urandom);
          d = {d[55:0], by};
        end
        msg_if.data  = d;
        msg_if.valid = 1'b1;
        msg_if.sop   = (b == 0);
        msg_if.eop   = (b == nb - 1);
        msg_if.empty = (b == nb - 1) ? 3'(8 * nb - act_len[i])
                                     : 3'($urandom);
        msg_len = (b == 0) ? 16'(dec_len[i]) : 16'($urandom);
        while (!acc && w < 500) begin
          @(negedge clk);
          acc = msg_if.ready;
          @(posedge clk);
          #1;
          w++;
        end
        if (!acc) begin
          n_chk++;
          n_fail++;
          $display("FAIL drive_timeout msg%0d beat%0d not accepted", i, b);
          abort = 1;
        end
        if (gap_en != 0 && $urandom_range(0, 2) == 0) begin
          msg_if.valid = 1'b0;
          repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
    msg_if.valid = 1'b0;
    msg_if.sop   = 1'b0;
    msg_if.eop   = 1'b0;
  endtask

  task automatic sink();
    int  k = 0;
    bit  fin = 0;
    while (!fin && k < 2000) begin
      logic r;
      @(negedge clk);
      r = !(k >= stall_start && k < stall_start + stall_len) &&
          (sink_mode == 0 || $urandom_range(0, 2) != 0);
      pkt_if.ready = r;
      if (r && pkt_if.valid) begin
        word_t wd;
        wd.d   = pkt_if.data;
        wd.sop = pkt_if.sop;
        wd.eop = pkt_if.eop;
        wd.err = pkt_if.error;
        wd.emp = pkt_if.empty;
        got.push_back(wd);
        if (pkt_if.eop) fin = 1;
      end
      k++;
    end
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL sink_timeout no eop word, got %0d words", got.size());
    end
    done = 1;
  endtask

  task automatic watch();
    int occ = 0;
    int eops = 0;
    int cfg_eff = (pkt_cfg == 0) ? 1 : pkt_cfg;
    bit started = 0;
    while (!done) begin
      @(negedge clk);
      #1;
      if (done) break;
      if (!started) begin
        if (msg_if.valid && msg_if.sop && !busy) begin
          started = 1;
          occ = 2;
        end
      end else begin
        logic er, ev;
        int   inb = 0;
        er = (eops < cfg_eff) && occ <= 14;
        ev = occ >= 8 || (eops >= cfg_eff && occ > 0);
        n_chk++;
        if (msg_if.ready !== er) begin
          n_fail++;
          $display("FAIL msg_ready got %b exp %b occ %0d", msg_if.ready, er, occ);
        end
        n_chk++;
        if (pkt_if.valid !== ev) begin
          n_fail++;
          $display("FAIL pkt_valid got %b exp %b occ %0d", pkt_if.valid, ev, occ);
        end
        if (er && msg_if.valid) begin
          inb = (msg_if.sop ? 2 : 0) +
                (msg_if.eop ? 8 - int'(msg_if.empty) : 8);
          if (msg_if.eop) eops++;
        end
        if (ev && pkt_if.ready) occ = (occ > 8) ? occ - 8 : 0;
        occ += inb;
      end
    end
  endtask

  task automatic run_pkt(string tag);
    int nw;
    @(posedge clk);
    #1;
    got.delete();
    exp_b.delete();
    done = 0;
    exp_err = (pkt_cfg == 0);
    exp_b.push_back(8'(pkt_cfg >> 8));
    exp_b.push_back(8'(pkt_cfg));
    for (int i = 0; i < n_msgs; i++) begin
      exp_b.push_back(8'(dec_len[i] >> 8));
      exp_b.push_back(8'(dec_len[i]));
      for (int k = 0; k < act_len[i]; k++) exp_b.push_back(mb[i][k]);
      if (act_len[i] != dec_len[i]) exp_err = 1;
    end
    cfg_msg_count = 16'(pkt_cfg);
    fork
      drive_msgs();
      sink();
      watch();
    join
    nw = (exp_b.size() + 7) / 8;
    n_chk++;
    if (got.size() != nw) begin
      n_fail++;
      $display("FAIL %s word_count got %0d exp %0d", tag, got.size(), nw);
    end
    for (int w = 0; w < nw && w < got.size(); w++) begin
      logic [63:0] ed = '0;
      logic [63:0] em = '0;
      logic        last = (w == nw - 1);
      logic [2:0]  ee = last ? 3'((8 - exp_b.size() % 8) % 8) : 3'd0;
      for (int k = 0; k < 8; k++) begin
        int idx = w * 8 + k;
        if (idx < exp_b.size()) begin
          ed[63 - 8 * k -: 8] = exp_b[idx];
          em[63 - 8 * k -: 8] = 8'hFF;
        end
      end
      n_chk++;
      if ((got[w].d & em) !== ed) begin
        n_fail++;
        $display("FAIL %s word%0d data got %h exp %h", tag, w, got[w].d & em, ed);
      end
      n_chk++;
      if (got[w].sop !== (w == 0)) begin
        n_fail++;
        $display("FAIL %s word%0d sop got %b", tag, w, got[w].sop);
      end
      n_chk++;
      if (got[w].eop !== last) begin
        n_fail++;
        $display("FAIL %s word%0d eop got %b exp %b", tag, w, got[w].eop, last);
      end
      n_chk++;
      if (got[w].emp !== ee) begin
        n_fail++;
        $display("FAIL %s word%0d empty got %0d exp %0d", tag, w, got[w].emp, ee);
      end
      n_chk++;
      if (got[w].err !== (last && exp_err)) begin
        n_fail++;
        $display("FAIL %s word%0d error got %b exp %b", tag, w, got[w].err, last && exp_err);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (pkt_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", pkt_if.valid); end
    n_chk++;
    if (pkt_if.sop !== 1'b0 || pkt_if.eop !== 1'b0) begin n_fail++; $display("FAIL rst_sop_eop got %b%b exp 00", pkt_if.sop, pkt_if.eop); end
    n_chk++;
    if (pkt_if.error !== 1'b0) begin n_fail++; $display("FAIL rst_error got %b exp 0", pkt_if.error); end
    n_chk++;
    if (pkt_if.empty !== 3'd0) begin n_fail++; $display("FAIL rst_empty got %0d exp 0", pkt_if.empty); end
    n_chk++;
    if (msg_if.ready !== 1'b0) begin n_fail++; $display("FAIL rst_msg_ready got %b exp 0", msg_if.ready); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    reset_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || msg_if.ready !== 1'b0) begin n_fail++; $display("FAIL idle_after_rst busy %b ready %b exp 0 0", busy, msg_if.ready); end
  endtask

  task automatic test_single();
    pkt_cfg = 1; n_msgs = 1;
    set_msg(0, 5, 5, 'hAA, 'h11);
    run_pkt("single");
    n_chk++;
    if (got.size() < 1 || got[0].d !== 64'h0001_0005_AABB_CCDD) begin
      n_fail++; $display("FAIL single_w0 got %h exp 0001_0005_aabb_ccdd", got.size() > 0 ? got[0].d : 64'h0);
    end
    n_chk++;
    if (got.size() < 2 || got[1].d[63:56] !== 8'hEE || got[1].emp !== 3'd7) begin
      n_fail++; $display("FAIL single_w1 got words %0d exp EE with empty 7", got.size());
    end
  endtask

  task automatic test_two();
    pkt_cfg = 2; n_msgs = 2;
    set_msg(0, 4, 4, 'h11, 'h11);
    set_msg(1, 4, 4, 'h55, 'h11);
    run_pkt("two");
    n_chk++;
    if (got.size() < 2 || got[1].d[63:16] !== 48'h0004_5566_7788 || got[1].emp !== 3'd2) begin
      n_fail++; $display("FAIL two_w1 got words %0d exp 0004_5566_7788 empty 2", got.size());
    end
  endtask

  task automatic test_back_to_back();
    pkt_cfg = 3; n_msgs = 3;
    for (int i = 0; i < 3; i++) set_rand(i, 8);
    run_pkt("b2b");
    n_chk++;
    if (got.size() != 4 || got[3].emp !== 3'd0) begin
      n_fail++; $display("FAIL b2b_shape got %0d words exp 4 with empty 0", got.size());
    end
  endtask

  task automatic test_backpressure();
    pkt_cfg = 1; n_msgs = 1;
    set_rand(0, 20);
    stall_start = 2; stall_len = 10;
    run_pkt("stall");
    stall_len = 0;
  endtask

  task automatic test_len_err();
    pkt_cfg = 1; n_msgs = 1;
    set_msg(0, 5, 6, 'h30, 1);
    run_pkt("len_err");
    n_chk++;
    if (got.size() < 1 || got[0].d[47:32] !== 16'h0006) begin
      n_fail++; $display("FAIL len_err_field got words %0d exp length 0006", got.size());
    end
  endtask

  task automatic test_zero_cfg();
    pkt_cfg = 0; n_msgs = 1;
    set_rand(0, 3);
    run_pkt("zero_cfg");
  endtask

  task automatic test_reset_flush();
    @(posedge clk);
    #1;
    pkt_cfg = 1; n_msgs = 1;
    set_rand(0, 12);
    cfg_msg_count = 16'd1;
    pkt_if.ready = 1'b0;
    drive_msgs();
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || pkt_if.valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_rst_flush busy %b valid %b exp 1 1", busy, pkt_if.valid);
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (pkt_if.valid !== 1'b0 || busy !== 1'b0 || msg_if.ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_flush valid %b busy %b ready %b exp 0 0 0", pkt_if.valid, busy, msg_if.ready);
    end
    reset_n = 1'b1;
    pkt_if.ready = 1'b1;
    set_msg(0, 1, 1, 'h5A, 0);
    run_pkt("after_rst");
    n_chk++;
    if (got.size() != 1 || got[0].d[63:24] !== 40'h0001_0001_5A || got[0].emp !== 3'd3) begin
      n_fail++; $display("FAIL after_rst_word got %0d words exp one 00010001_5A empty 3", got.size());
    end
  endtask

  task automatic test_random();
    sink_mode = 1;
    gap_en = 1;
    for (int p = 0; p < 10; p++) begin
      pkt_cfg = $urandom_range(1, 4);
      n_msgs = pkt_cfg;
      for (int i = 0; i < n_msgs; i++) set_rand(i, $urandom_range(1, 30));
      if (p == 6) dec_len[0] = act_len[0] + 1;
      run_pkt("random");
    end
    sink_mode = 0;
    gap_en = 0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    msg_if.data = '0;
    msg_if.valid = 1'b0;
    msg_if.sop = 1'b0;
    msg_if.eop = 1'b0;
    msg_if.empty = 3'd0;
    msg_if.error = 1'b0;
    pkt_if.ready = 1'b1;
    msg_len = '0;
    cfg_msg_count = '0;
    sink_mode = 0;
    stall_start = 0;
    stall_len = 0;
    gap_en = 0;
    test_reset();
    test_single();
    test_two();
    test_back_to_back();
    test_backpressure();
    test_len_err();
    test_zero_cfg();
    test_reset_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
